// File: rtl/sht40_target_model.sv
// sht40_target_model: I2C target that stands in for an SHT40 sensor.
// A write of CMD_MEASURE arms a measurement. After MEAS_DELAY clk cycles, a read
// returns T_MSB, T_LSB, T_CRC, RH_MSB, RH_LSB, RH_CRC, followed by 0xFF filler.
// Samples arrive on an AXI-stream slave. The first beat is temperature and the second is RH.
// s_axis handshake: a beat transfers on a clk edge where s_axis_tvalid && s_axis_tready.
// tready depends only on how many words are held, never on tvalid.
// Optional build macro SHT_CRC_INJECT_EN adds crc_err_inject. It flips bit 0 of the stored CRCs.
module sht40_target_model #(
   parameter logic [6:0] DEV_ADDR       = 7'h44,
   parameter logic [7:0] CMD_MEASURE    = 8'hE0,
   parameter logic [7:0] CMD_SOFT_RESET = 8'h94,
   parameter int         MEAS_DELAY     = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Scl_In,
   input  logic        Sda_In,
   output logic        Sda_Out,
   input  logic [15:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic        cmd_valid,
   output logic [7:0]  cmd_byte,
   output logic        busy
`ifdef SHT_CRC_INJECT_EN
   ,
   input  logic        crc_err_inject
`endif
);

   localparam int DW = (MEAS_DELAY < 1) ? 1 : $clog2(MEAS_DELAY + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_CMD, S_CMD_ACK, S_TX_BYTE, S_TX_ACK, S_WAIT_STOP
   } state_t;

   // CRC-8: polynomial 0x31, init 0xFF, MSB first over the 16-bit word
   function automatic logic [7:0] crc8(input logic [15:0] d);
      logic [7:0] c;
      logic       fb;
      c = 8'hFF;
      for (int i = 15; i >= 0; i--) begin
         fb = c[7] ^ d[i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h31 : 8'h00);
      end
      return c;
   endfunction

   function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [15:0] tw,
                                              input logic [15:0] rw, input logic [7:0] tc,
                                              input logic [7:0] rc);
      case (i)
         3'd0:    return tw[15:8];
         3'd1:    return tw[7:0];
         3'd2:    return tc;
         3'd3:    return rw[15:8];
         3'd4:    return rw[7:0];
         3'd5:    return rc;
         default: return 8'hFF;
      endcase
   endfunction

   logic scl_s1, scl_s2, scl_h, sda_s1, sda_s2, sda_h;
   logic scl_rise, scl_fall, start_det, stop_det;

   state_t      state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  idx_q, idx_d, nxt_idx, bsel;
   logic        ack_q, ack_d, sda_q, sda_d, busy_q, busy_d;
   logic [7:0]  cmd_byte_q, cmd_byte_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic        meas_evt, soft_evt, frame_done;

   logic [1:0]  cnt_q, cnt_base;
   logic [15:0] t_word_q, rh_word_q;
   logic [7:0]  t_crc_q, rh_crc_q;
   logic [DW-1:0] delay_q;
   logic        pending_q, ready, beat, inj;
   logic [7:0]  first_byte, cur_byte, nxt_byte;

`ifdef SHT_CRC_INJECT_EN
   assign inj = crc_err_inject;
`else
   assign inj = 1'b0;
`endif

   assign scl_rise  = scl_s2 & ~scl_h;
   assign scl_fall  = ~scl_s2 & scl_h;
   assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
   assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;

   assign s_axis_tready = (cnt_q != 2'd2);
   assign beat          = s_axis_tvalid & s_axis_tready;
   assign ready         = (cnt_q == 2'd2) && (delay_q == '0) && pending_q;
   assign nxt_idx       = (idx_q == 3'd7) ? 3'd7 : idx_q + 3'd1;
   assign bsel          = 3'd7 - bit_cnt_q[2:0];
   assign first_byte    = frame_byte(3'd0, t_word_q, rh_word_q, t_crc_q, rh_crc_q);
   assign cur_byte      = frame_byte(idx_q, t_word_q, rh_word_q, t_crc_q, rh_crc_q);
   assign nxt_byte      = frame_byte(nxt_idx, t_word_q, rh_word_q, t_crc_q, rh_crc_q);

   assign Sda_Out   = sda_q;
   assign busy      = busy_q;
   assign cmd_byte  = cmd_byte_q;
   assign cmd_valid = cmd_valid_q;

   // Two-stage synchronizers plus one history stage for edge detection (idle bus is high)
   always_ff @(posedge clk) begin
      if (rst) begin
         {scl_s1, scl_s2, scl_h} <= 3'b111;
         {sda_s1, sda_s2, sda_h} <= 3'b111;
      end else begin
         {scl_s1, scl_s2, scl_h} <= {Scl_In, scl_s1, scl_s2};
         {sda_s1, sda_s2, sda_h} <= {Sda_In, sda_s1, sda_s2};
      end
   end

   // Bus FSM state register and registered bus-side outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= 4'd0;
         shift_q     <= 8'd0;
         idx_q       <= 3'd0;
         ack_q       <= 1'b1;
         sda_q       <= 1'b1;
         busy_q      <= 1'b0;
         cmd_byte_q  <= 8'd0;
         cmd_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         idx_q       <= idx_d;
         ack_q       <= ack_d;
         sda_q       <= sda_d;
         busy_q      <= busy_d;
         cmd_byte_q  <= cmd_byte_d;
         cmd_valid_q <= cmd_valid_d;
      end
   end

   // Next-state logic: bits shift in on SCL rise, and SDA is re-driven only on SCL fall
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      idx_d       = idx_q;
      ack_d       = ack_q;
      sda_d       = sda_q;
      busy_d      = busy_q;
      cmd_byte_d  = cmd_byte_q;
      cmd_valid_d = 1'b0;
      meas_evt    = 1'b0;
      soft_evt    = 1'b0;
      frame_done  = 1'b0;
      if (stop_det) begin
         state_d = S_IDLE;
         sda_d   = 1'b1;
         busy_d  = 1'b0;
      end else if (start_det) begin
         state_d   = S_ADDR;
         bit_cnt_d = 4'd0;
         sda_d     = 1'b1;
      end else begin
         case (state_q)
            S_ADDR, S_CMD: begin
               if (scl_rise && bit_cnt_q != 4'd8) begin
                  shift_d   = {shift_q[6:0], sda_s2};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  bit_cnt_d = 4'd0;
                  if (state_q == S_CMD) begin
                     state_d     = S_CMD_ACK;
                     sda_d       = 1'b0;
                     cmd_byte_d  = shift_q;
                     cmd_valid_d = 1'b1;
                     meas_evt    = (shift_q == CMD_MEASURE);
                     soft_evt    = (shift_q == CMD_SOFT_RESET);
                  end else if (shift_q[7:1] != DEV_ADDR) begin
                     state_d = S_IDLE;
                     busy_d  = 1'b0;
                  end else if (!shift_q[0] || ready) begin
                     state_d = S_ADDR_ACK;
                     sda_d   = 1'b0;
                     busy_d  = 1'b1;
                  end else begin
                     // Read before the measurement is ready: address NACK
                     state_d = S_IDLE;
                     busy_d  = 1'b1;
                  end
               end
            end
            S_ADDR_ACK: begin
               if (scl_fall) begin
                  if (shift_q[0]) begin
                     state_d   = S_TX_BYTE;
                     idx_d     = 3'd0;
                     sda_d     = first_byte[7];
                     bit_cnt_d = 4'd1;
                  end else begin
                     state_d   = S_CMD;
                     sda_d     = 1'b1;
                     bit_cnt_d = 4'd0;
                  end
               end
            end
            S_CMD_ACK: begin
               if (scl_fall) begin
                  state_d   = S_CMD;
                  sda_d     = 1'b1;
                  bit_cnt_d = 4'd0;
               end
            end
            S_TX_BYTE: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     state_d = S_TX_ACK;
                     sda_d   = 1'b1;
                  end else begin
                     sda_d     = cur_byte[bsel];
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            S_TX_ACK: begin
               if (scl_rise) begin
                  ack_d = sda_s2;
               end else if (scl_fall) begin
                  if (!ack_q) begin
                     state_d   = S_TX_BYTE;
                     idx_d     = nxt_idx;
                     sda_d     = nxt_byte[7];
                     bit_cnt_d = 4'd1;
                  end else begin
                     state_d    = S_WAIT_STOP;
                     sda_d      = 1'b1;
                     frame_done = (idx_q >= 3'd5);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Sample buffer: a clear (soft reset or consumed frame) still accepts a same-cycle beat
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= 2'd0;
         t_word_q  <= 16'd0;
         rh_word_q <= 16'd0;
         t_crc_q   <= 8'd0;
         rh_crc_q  <= 8'd0;
      end else begin
         cnt_q <= cnt_base;
         if (beat) begin
            cnt_q <= cnt_base + 2'd1;
            if (cnt_base == 2'd0) begin
               t_word_q <= s_axis_tdata;
               t_crc_q  <= crc8(s_axis_tdata) ^ {7'd0, inj};
            end else begin
               rh_word_q <= s_axis_tdata;
               rh_crc_q  <= crc8(s_axis_tdata) ^ {7'd0, inj};
            end
         end
      end
   end

   assign cnt_base = (soft_evt || frame_done) ? 2'd0 : cnt_q;

   // Measurement delay counter, which saturates at zero, and the pending flag
   always_ff @(posedge clk) begin
      if (rst) begin
         delay_q   <= '0;
         pending_q <= 1'b0;
      end else if (meas_evt) begin
         delay_q   <= DW'(MEAS_DELAY);
         pending_q <= 1'b1;
      end else begin
         if (delay_q != '0) delay_q <= delay_q - DW'(1);
         if (soft_evt || frame_done) pending_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sht40_target_model.sv
// Bench for sht40_target_model: a bit-banged I2C master on an open-drain bus.
// Master observations are scoreboarded against hand-computed expected queues.
module tb_sht40_target_model;

   localparam int Q = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        scl_m, sda_m;
   logic        sda_line;
   logic        Sda_Out;
   logic [15:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic        cmd_valid;
   logic [7:0]  cmd_byte;
   logic        busy;
`ifdef SHT_CRC_INJECT_EN
   logic        crc_err_inject = 1'b0;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];
   logic [7:0]  exp_cmd_q[$];
   logic        obs_valid = 1'b0;
   logic [15:0] obs_data = 16'd0;
   int          low_cnt = 0;
   int          snap;
   logic        bit_v;
   logic [7:0]  frame_tbl [0:7];

   always #5 clk = ~clk;

   assign sda_line = sda_m & Sda_Out;

   sht40_target_model dut (
      .clk           (clk),
      .rst           (rst),
      .Scl_In        (scl_m),
      .Sda_In        (sda_line),
      .Sda_Out       (Sda_Out),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .cmd_valid     (cmd_valid),
      .cmd_byte      (cmd_byte),
      .busy          (busy)
`ifdef SHT_CRC_INJECT_EN
      ,
      .crc_err_inject(crc_err_inject)
`endif
   );

   // Count every cycle in which the target pulls SDA low
   always @(posedge clk) if (Sda_Out == 1'b0) low_cnt <= low_cnt + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic emit(input logic [15:0] v);
      obs_data  = v;
      obs_valid = 1'b1;
      @(negedge clk);
      obs_valid = 1'b0;
   endtask

   task automatic obs_monitor();
      logic [15:0] e;
      forever begin
         @(posedge clk);
         if (obs_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL obs_unexpected: got %h expected none", obs_data);
            end else begin
               e = exp_q.pop_front();
               if (obs_data !== e) begin
                  errors++;
                  $display("FAIL %s: got %h expected %h",
                           (e[15:8] == 8'h01) ? "rd_byte" : "ack_bit", obs_data, e);
               end
            end
         end
      end
   endtask

   task automatic cmd_monitor();
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (cmd_valid) begin
            checks++;
            if (exp_cmd_q.size() == 0) begin
               errors++;
               $display("FAIL cmd_unexpected: got %h expected none", cmd_byte);
            end else begin
               e = exp_cmd_q.pop_front();
               if (cmd_byte !== e) begin
                  errors++;
                  $display("FAIL cmd_byte: got %h expected %h", cmd_byte, e);
               end
            end
         end
      end
   endtask

   task automatic push_sample(input logic [15:0] w);
      int n;
      @(negedge clk);
      s_axis_tdata  = w;
      s_axis_tvalid = 1'b1;
      n = 0;
      while (!s_axis_tready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!s_axis_tready) begin
         errors++;
         $display("FAIL axis_push: got tready=0 expected tready=1 within 20 cycles");
      end
      @(negedge clk);
      s_axis_tvalid = 1'b0;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; scl_m = 1'b1; wait_clk(Q);
      sda_m = 1'b0; wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      sda_m = 1'b1; wait_clk(2 * Q);
   endtask

   task automatic write_bit(input logic b);
      sda_m = b; wait_clk(Q);
      scl_m = 1'b1; wait_clk(2 * Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      b = sda_line; wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic write_byte(input logic [7:0] v, input logic exp_ack);
      logic a;
      exp_q.push_back({8'h02, 7'd0, exp_ack});
      for (int i = 7; i >= 0; i--) write_bit(v[i]);
      read_bit(a);
      emit({8'h02, 7'd0, a});
   endtask

   task automatic read_byte(input logic [7:0] exp_v, input logic m_ack);
      logic [7:0] b;
      logic       x;
      exp_q.push_back({8'h01, exp_v});
      for (int i = 7; i >= 0; i--) begin
         read_bit(x);
         b[i] = x;
      end
      write_bit(m_ack);
      emit({8'h01, b});
   endtask

   task automatic measure();
      i2c_start();
      write_byte(8'h88, 1'b0);
      exp_cmd_q.push_back(8'hE0);
      write_byte(8'hE0, 1'b0);
      i2c_stop();
   endtask

   task automatic read_frame(input int n);
      i2c_start();
      write_byte(8'h89, 1'b0);
      check("busy_in_read", {15'd0, busy}, 16'd1);
      for (int i = 0; i < n; i++) read_byte(frame_tbl[i], (i == n - 1));
      i2c_stop();
   endtask

   initial begin
      frame_tbl[0] = 8'hBE; frame_tbl[1] = 8'hEF; frame_tbl[2] = 8'h92; frame_tbl[3] = 8'h00;
      frame_tbl[4] = 8'h00; frame_tbl[5] = 8'h81; frame_tbl[6] = 8'hFF; frame_tbl[7] = 8'hFF;
      rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
      s_axis_tdata = 16'd0; s_axis_tvalid = 1'b0;
      fork
         obs_monitor();
         cmd_monitor();
      join_none
      wait_clk(5);
      rst = 1'b0;
      wait_clk(2);
      check("rst_sda_out", {15'd0, Sda_Out}, 16'd1);
      check("rst_tready", {15'd0, s_axis_tready}, 16'd1);
      check("rst_cmd_valid", {15'd0, cmd_valid}, 16'd0);
      check("rst_cmd_byte", {8'd0, cmd_byte}, 16'd0);
      check("rst_busy", {15'd0, busy}, 16'd0);

      // Normal measurement
      push_sample(16'hBEEF);
      push_sample(16'h0000);
      check("full_tready", {15'd0, s_axis_tready}, 16'd0);
      measure();
      wait_clk(1100);
      read_frame(6);
      check("normal_tready", {15'd0, s_axis_tready}, 16'd1);
      check("normal_busy", {15'd0, busy}, 16'd0);

      // Early read: the address is NACKed and SDA is never pulled low
      push_sample(16'hBEEF);
      push_sample(16'h0000);
      measure();
      snap = low_cnt;
      i2c_start();
      write_byte(8'h89, 1'b1);
      i2c_stop();
      check("early_sda_low", 16'(low_cnt - snap), 16'd0);
      check("early_busy", {15'd0, busy}, 16'd0);

      // Over-read: 8 bytes, then the NACK on the last byte consumes the frame
      wait_clk(1100);
      read_frame(8);
      check("overread_tready", {15'd0, s_axis_tready}, 16'd1);
      i2c_start();
      write_byte(8'h89, 1'b1);
      i2c_stop();

      // Wrong address: no ACK, no command, not busy
      snap = low_cnt;
      i2c_start();
      write_byte(8'h8A, 1'b1);
      write_byte(8'hE0, 1'b1);
      i2c_stop();
      check("wrong_sda_low", 16'(low_cnt - snap), 16'd0);
      check("wrong_busy", {15'd0, busy}, 16'd0);

      // Soft reset after a measure empties the buffer and cancels the pending measurement
      push_sample(16'hBEEF);
      push_sample(16'h0000);
      check("soft_full_tready", {15'd0, s_axis_tready}, 16'd0);
      measure();
      i2c_start();
      write_byte(8'h88, 1'b0);
      exp_cmd_q.push_back(8'h94);
      write_byte(8'h94, 1'b0);
      i2c_stop();
      check("soft_tready", {15'd0, s_axis_tready}, 16'd1);
      wait_clk(1100);
      i2c_start();
      write_byte(8'h89, 1'b1);
      i2c_stop();

      // Reset in the middle of byte 2 (0x92), while the target drives bit 6 = 0
      push_sample(16'hBEEF);
      push_sample(16'h0000);
      measure();
      wait_clk(1100);
      i2c_start();
      write_byte(8'h89, 1'b0);
      read_byte(8'hBE, 1'b0);
      read_byte(8'hEF, 1'b0);
      read_bit(bit_v);
      check("mid_bit7", {15'd0, bit_v}, 16'd1);
      check("mid_sda_driven", {15'd0, Sda_Out}, 16'd0);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_sda", {15'd0, Sda_Out}, 16'd1);
      rst = 1'b0;
      check("mid_rst_tready", {15'd0, s_axis_tready}, 16'd1);
      check("mid_rst_busy", {15'd0, busy}, 16'd0);
      i2c_stop();
      push_sample(16'hBEEF);
      push_sample(16'h0000);
      measure();
      wait_clk(1100);
      read_frame(6);
      check("after_rst_tready", {15'd0, s_axis_tready}, 16'd1);

      wait_clk(20);
      check("exp_q_drained", 16'(exp_q.size()), 16'd0);
      check("exp_cmd_q_drained", 16'(exp_cmd_q.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sht40_target_model.md
Name: sht40_target_model

Overview:
- Synthesizable I2C target (slave) that emulates an SHT40 humidity/temperature sensor at the far end of the two-wire bus.
- Accepts a measurement command from an I2C master, then answers the read with a 6-byte frame: T_MSB, T_LSB, T_CRC, RH_MSB, RH_LSB, RH_CRC.
- Temperature and humidity values come in over an AXI-stream slave, the mirror of the master-side m_axis output.
- Used on-board as a loop-back sensor stand-in and in benches for the I2C master.

Parameters:
- DEV_ADDR, 7'h44, 7-bit target address.
- CMD_MEASURE, 8'hE0, command byte that starts a measurement.
- CMD_SOFT_RESET, 8'h94, command byte that clears the sample buffer and measurement state.
- MEAS_DELAY, 1000, clk cycles after a valid measure command before reads are ACKed.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- Scl_In  in  1  raw SCL from pad (asynchronous).
- Sda_In  in  1  raw SDA from pad (asynchronous).
- Sda_Out  out  1  1 = release (pad Z), 0 = pull low.
- s_axis_tdata  in  16  sample word; first beat = temperature, second beat = RH.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  buffer can accept a beat.
- cmd_valid  out  1  one-cycle pulse when a command byte is ACKed.
- cmd_byte  out  8  last received command byte.
- busy  out  1  high from START to STOP while this target is addressed.

Behaviour:
- Reset values: Sda_Out=1, s_axis_tready=1, cmd_valid=0, cmd_byte=0, busy=0. Buffer is empty, state is IDLE, delay counter is 0.
- Reset is synchronous to clk. Asserting it mid-transfer releases SDA on the next cycle and returns to IDLE; the transfer is abandoned.
- Input conditioning: SCL and SDA each pass through a 2-FF synchronizer plus one history FF. Edge detection uses the synchronized values.
- START is SDA falling while SCL is high. STOP is SDA rising while SCL is high.
- Bit timing:
  - Input bits are sampled on SCL rising edges.
  - Sda_Out changes only on the clk cycle after a detected SCL falling edge.
- State machine:
  - IDLE: wait for START, then go to ADDR.
  - ADDR: shift in 8 bits, MSB first. If addr==DEV_ADDR: on a write go to ADDR_ACK; on a read go to ADDR_ACK only if ready, otherwise NACK and go to IDLE. On address mismatch go to IDLE and keep SDA released.
  - ready means: both samples present AND delay counter == 0 AND a measure is pending.
  - ADDR_ACK: drive 0 for the 9th bit. Then go to CMD on a write, or TX_BYTE with index 0 on a read.
  - CMD: shift in 8 bits, then go to CMD_ACK. Every command byte is ACKed. cmd_byte is updated and cmd_valid pulses at the ACK bit.
  - Command effects: CMD_MEASURE loads the delay counter with MEAS_DELAY and sets the pending flag. CMD_SOFT_RESET empties the buffer and clears pending. Any other command is ignored.
  - TX_BYTE: drive the frame byte at index, MSB first. Index 6 and above sends 8'hFF.
  - TX_ACK: release SDA and sample the master's ACK. ACK (0) increments the index and returns to TX_BYTE. NACK (1) goes to WAIT_STOP.
  - Frame consumption: a NACK with index >= 5 (full frame read) clears pending and empties the buffer.
- START in any state (repeated start) goes to ADDR. STOP in any state goes to IDLE with SDA released.
- AXI-stream input:
  - s_axis_tready = 1 while fewer than 2 words are buffered.
  - A beat is taken when tvalid && tready: word 0 is temperature, word 1 is RH.
  - Beats with the buffer full are not accepted (tready=0).
- CRC-8: polynomial 0x31, init 0xFF, no final XOR, computed over each 16-bit word. CRC is computed when the word is loaded, not on the fly.
- Delay counter: decrements every clk while nonzero and saturates at 0. A new CMD_MEASURE during the delay reloads it.
- busy: set at address match, cleared at STOP or on an address mismatch.

Optional Feature:
- Macro SHT_CRC_INJECT_EN.
- When defined: adds input port crc_err_inject (1 bit). While it is high at buffer load, both CRC bytes are stored with bit 0 inverted.
- When undefined: the port is absent and CRCs are always correct.

Test Plan:
- Normal measurement:
  - Push s_axis 0xBEEF, then 0x0000.
  - Master writes 0x88 then 0xE0; both are ACKed, cmd_valid pulses once with cmd_byte=0xE0.
  - After MEAS_DELAY, master reads 0x89 and 6 bytes -> BE EF 92 00 00 81.
  - Afterwards s_axis_tready=1.
- Early read: read 0x89 issued before MEAS_DELAY expires -> address NACKed, SDA never driven low, busy=0 after STOP.
- Wrong address: write 0x8A, 0xE0 -> no ACK on any bit, cmd_valid stays 0, busy stays 0.
- Over-read: master ACKs 8 bytes -> bytes 6 and 7 are 0xFF. Master NACK on the last byte -> buffer empties.
- Soft reset: load samples, send 0x94, then read -> address NACKed, s_axis_tready=1.
- Reset mid-transfer: assert rst during byte 2 of the read -> Sda_Out=1 next cycle. A subsequent START followed by a correct sequence behaves as in the normal measurement test.
